// File: rtl/axi_rd_pkg.sv
// Shared AXI read-channel constants and FSM state type for the window read slave.
package axi_rd_pkg;

  // Read response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Burst type codes
  localparam logic [1:0] FIXED    = 2'b00;
  localparam logic [1:0] INCR     = 2'b01;
  localparam logic [1:0] WRAP     = 2'b10;
  localparam logic [1:0] RESERVED = 2'b11;

  // Read FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_BEAT  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/window_ram_sdp.sv
// Simple dual-port window RAM: one write port, one registered read port, read-first.
// The read register can be loaded with zero instead of memory data (error beats).
module window_ram_sdp #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rzero_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int unsigned WORDS = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read port register; non-blocking read gives old data on a same-address write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= rzero_i ? '0 : mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_window_read_slave.sv
// AXI4 read-channel slave serving full-width beats from a loadable window memory.
// Optional completed-beat counter is built when AXI_RD_BEAT_CNT_EN is defined.
module axi_window_read_slave
  import axi_rd_pkg::*;
#(
  parameter int unsigned DATA_BYTE_WIDTH = 32,
  parameter int unsigned DATA_BYTE_SHIFT = 5,
  parameter int unsigned DEPTH_INDEX     = 7,
  parameter int unsigned DEPTH           = 100,
  parameter int unsigned ID_WIDTH        = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [DEPTH_INDEX-1:0]       wr_addr,
  input  logic [DATA_BYTE_WIDTH*8-1:0] wr_data,
  output logic                         busy,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [31:0]                  s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_BYTE_WIDTH*8-1:0] s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  output logic [31:0]                  rd_beat_cnt
);

  localparam int unsigned DATA_W = DATA_BYTE_WIDTH * 8;
  // Extra headroom so an INCR burst never wraps back into the valid window
  localparam int unsigned WA_W   = DEPTH_INDEX + 9;

  rd_state_e             state_q, state_d;
  logic [WA_W-1:0]       waddr_q, waddr_d;
  logic [7:0]            beats_q, beats_d;
  logic [1:0]            burst_q, burst_d;
  logic                  err_q, err_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic                  busy_q, busy_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic                  ar_hs, r_hs, beat_bad;
  logic                  unused_araddr;

  assign ar_hs    = (state_q == S_IDLE) && arready_q && s_axi_arvalid;
  assign r_hs     = rvalid_q && s_axi_rready;
  assign beat_bad = err_q || (waddr_q >= WA_W'(DEPTH));

  // Byte-offset and high address bits play no part in word selection
  assign unused_araddr = ^{s_axi_araddr[31:DATA_BYTE_SHIFT+DEPTH_INDEX],
                           s_axi_araddr[DATA_BYTE_SHIFT-1:0]};

  // State and registered-output update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      waddr_q   <= '0;
      beats_q   <= '0;
      burst_q   <= FIXED;
      err_q     <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      rresp_q   <= OKAY;
      rid_q     <= '0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      beats_q   <= beats_d;
      burst_q   <= burst_d;
      err_q     <= err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      busy_q    <= busy_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    beats_d   = beats_q;
    burst_d   = burst_q;
    err_d     = err_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    busy_d    = busy_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    case (state_q)
      S_IDLE: begin
        arready_d = 1'b1;
        rvalid_d  = 1'b0;
        if (ar_hs) begin
          state_d   = S_FETCH;
          arready_d = 1'b0;
          busy_d    = 1'b1;
          rid_d     = s_axi_arid;
          waddr_d   = WA_W'(s_axi_araddr[DATA_BYTE_SHIFT+DEPTH_INDEX-1:DATA_BYTE_SHIFT]);
          beats_d   = s_axi_arlen;
          burst_d   = s_axi_arburst;
          err_d     = (s_axi_arsize != 3'(DATA_BYTE_SHIFT)) ||
                      (s_axi_arburst == WRAP) || (s_axi_arburst == RESERVED);
        end
      end
      S_FETCH: begin
        state_d  = S_BEAT;
        rvalid_d = 1'b1;
        rresp_d  = beat_bad ? SLVERR : OKAY;
        rlast_d  = (beats_q == 8'd0);
      end
      S_BEAT: begin
        if (r_hs) begin
          rvalid_d = 1'b0;
          if (rlast_q) begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            arready_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            beats_d = beats_q - 8'd1;
            if (burst_q == INCR) waddr_d = waddr_q + WA_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window memory; its read register is the rdata output register
  window_ram_sdp #(
    .ADDR_W (DEPTH_INDEX),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (state_q == S_FETCH),
    .rzero_i (beat_bad),
    .raddr_i (waddr_q[DEPTH_INDEX-1:0]),
    .rdata_o (s_axi_rdata)
  );

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign busy          = busy_q;

`ifdef AXI_RD_BEAT_CNT_EN
  logic [31:0] cnt_q;

  // Completed R beat counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt_q <= '0;
    else if (r_hs) cnt_q <= cnt_q + 32'd1;
  end

  assign rd_beat_cnt = cnt_q;
`else
  assign rd_beat_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_window_read_slave.sv
// Self-checking bench for axi_window_read_slave: directed bursts plus random bursts
// checked against an array model of the window and the AXI read rules.
module tb_axi_window_read_slave;

  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic [3:0]    arid;
  logic [31:0]   araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arvalid;
  logic          arready;
  logic [3:0]    rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rd_beat_cnt;

  int            n_checks = 0;
  int            n_errors = 0;
  int            beats_done = 0;
  logic [DW-1:0] mem_model [128];

  always #5 clk = ~clk;

  axi_window_read_slave dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .s_axi_arid    (arid),
    .s_axi_araddr  (araddr),
    .s_axi_arlen   (arlen),
    .s_axi_arsize  (arsize),
    .s_axi_arburst (arburst),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rid     (rid),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rlast   (rlast),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .rd_beat_cnt   (rd_beat_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef AXI_RD_BEAT_CNT_EN
    return 32'(beats_done);
`else
    return 32'd0;
`endif
  endfunction

  task automatic wr_word(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 7'(a); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    mem_model[a] = d;
  endtask

  // One read burst; optional stall on one beat, reset abort, and same-cycle write collision
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int stall_beat,
                           input int stall_cyc, input int abort_at, input bit coll,
                           input logic [DW-1:0] coll_data);
    int            base, w, t;
    bit            bad;
    logic [DW-1:0] ed;
    base = int'(addr[11:5]);
    t = 0;
    @(negedge clk);
    while (arready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    check("arready_idle", DW'(arready), DW'(1));
    if (arready !== 1'b1) return;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1; rready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    check("arready_drop", DW'(arready), DW'(0));
    check("busy_start", DW'(busy), DW'(1));
    check("rvalid_fetch", DW'(rvalid), DW'(0));
    if (coll) begin wr_en = 1'b1; wr_addr = 7'(base); wr_data = coll_data; end
    @(negedge clk);
    wr_en = 1'b0;
    check("first_rvalid_lat", DW'(rvalid), DW'(1));
    for (int i = 0; i <= len; i++) begin
      t = 0;
      while (rvalid !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      check("rvalid_wait", DW'(rvalid), DW'(1));
      if (rvalid !== 1'b1) return;
      w   = (burst == 1) ? base + i : base;
      bad = (size != 5) || (burst >= 2) || (w >= 100);
      ed  = bad ? '0 : mem_model[w];
      if (abort_at == i) begin
        rst_n = 1'b0;
        #1;
        beats_done = 0;
        check("rst_rvalid", DW'(rvalid), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_cnt", DW'(rd_beat_cnt), DW'(0));
        check("rst_arready", DW'(arready), DW'(0));
        check("rst_rdata", rdata, '0);
        return;
      end
      check("rdata", rdata, ed);
      check("rresp", DW'(rresp), bad ? DW'(2) : DW'(0));
      check("rlast", DW'(rlast), DW'(i == len));
      check("rid", DW'(rid), DW'(id));
      check("busy_beat", DW'(busy), DW'(1));
      if (coll && i == 0) mem_model[base] = coll_data;
      if (i == stall_beat && stall_cyc > 0) begin
        rready = 1'b0;
        for (int s = 0; s < stall_cyc; s++) begin
          @(negedge clk);
          check("stall_rvalid", DW'(rvalid), DW'(1));
          check("stall_rdata", rdata, ed);
          check("stall_rlast", DW'(rlast), DW'(i == len));
          check("stall_rresp", DW'(rresp), bad ? DW'(2) : DW'(0));
        end
        rready = 1'b1;
      end
      @(posedge clk);
      beats_done++;
      @(negedge clk);
    end
    check("end_busy", DW'(busy), DW'(0));
    check("end_rvalid", DW'(rvalid), DW'(0));
    check("end_arready", DW'(arready), DW'(1));
    check("beat_cnt", DW'(rd_beat_cnt), DW'(exp_cnt()));
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [31:0]   ra;
    int            rl;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_arready", DW'(arready), DW'(0));
    check("reset_rvalid", DW'(rvalid), DW'(0));
    check("reset_rlast", DW'(rlast), DW'(0));
    check("reset_rresp", DW'(rresp), DW'(0));
    check("reset_rid", DW'(rid), DW'(0));
    check("reset_rdata", rdata, '0);
    check("reset_busy", DW'(busy), DW'(0));
    check("reset_cnt", DW'(rd_beat_cnt), DW'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_arready", DW'(arready), DW'(1));

    // Preload: words 0..3 fixed pattern, the rest random
    for (int i = 0; i < 128; i++) begin
      if (i < 4) d = {8{32'(32'hA0 + i)}};
      else for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
      wr_word(i, d);
    end

    // Basic INCR burst, then the same with a 3-cycle stall on beat 2
    run_burst(4'h5, 32'h0, 3, 5, 1, -1, 0, -1, 1'b0, '0);
    run_burst(4'h5, 32'h0, 3, 5, 1, 1, 3, -1, 1'b0, '0);
    // FIXED burst on word 2
    run_burst(4'h3, 32'h40, 2, 5, 0, -1, 0, -1, 1'b0, '0);
    // Run off the end of the valid window
    run_burst(4'h7, 32'hC60, 1, 5, 1, -1, 0, -1, 1'b0, '0);
    run_burst(4'h8, 32'hFC0, 3, 5, 1, 2, 1, -1, 1'b0, '0);
    // Bad size, WRAP burst
    run_burst(4'h9, 32'h20, 0, 3, 1, -1, 0, -1, 1'b0, '0);
    run_burst(4'hA, 32'h20, 1, 5, 2, -1, 0, -1, 1'b0, '0);
    // Write to the word being fetched: first beat old data, second beat new
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom();
    run_burst(4'hB, 32'hA0, 1, 5, 0, -1, 0, -1, 1'b1, d);

    // Random bursts, low address bits random to show they are ignored
    for (int n = 0; n < 12; n++) begin
      ra = {20'h0, 7'($urandom_range(0, 127)), 5'($urandom())};
      rl = int'($urandom_range(0, 5));
      run_burst(4'($urandom()), ra, rl, ($urandom_range(0, 3) == 0) ? 3 : 5,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 3)), -1, 1'b0, '0);
    end

    // Reset during beat 2 of 4, then a normal burst
    run_burst(4'h2, 32'h0, 3, 5, 1, -1, 0, 1, 1'b0, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(4'hC, 32'h20, 3, 5, 1, 0, 2, -1, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
